// File: rtl/sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_schedule
// Description : SHA-256 message schedule. It loads M_0..M_15 from the input
//               shifter and expands them to W_0..W_(ROUNDS-1), one registered
//               word per cycle. Define MSG_SCHED_ABORT_EN to add the abort input.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_msg_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] M_i,
`ifdef MSG_SCHED_ABORT_EN
    input  logic        abort,
`endif
    output logic        ready,
    output logic [31:0] W_t,
    output logic [5:0]  t,
    output logic        w_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_EXPAND = 2'd2
    } state_t;

    localparam logic [5:0] c_last_t = 6'(ROUNDS - 1);
    localparam logic [5:0] c_load_last = 6'd14;

    state_t      r_state;
    logic [31:0] r_win [16];
    logic [31:0] w_new;
    logic        w_abort;

`ifdef MSG_SCHED_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    function automatic logic [31:0] f_rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] f_sigma0(input logic [31:0] x);
        return f_rotr(x, 7) ^ f_rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_sigma1(input logic [31:0] x);
        return f_rotr(x, 17) ^ f_rotr(x, 19) ^ (x >> 10);
    endfunction

    // r_win[15] is the newest word; r_win[0] is W_(t-15).
    assign w_new = f_sigma1(r_win[14]) + r_win[9] + f_sigma0(r_win[1]) + r_win[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            W_t     <= 32'd0;
            t       <= 6'd0;
            w_valid <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= 32'd0;
            end
        end else if (w_abort && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            w_valid <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !w_abort) begin
                        W_t     <= M_i;
                        t       <= 6'd0;
                        w_valid <= 1'b1;
                        busy    <= 1'b1;
                        ready   <= 1'b1;
                        for (int i = 0; i < 15; i++) begin
                            r_win[i] <= r_win[i+1];
                        end
                        r_win[15] <= M_i;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    W_t <= M_i;
                    t   <= t + 6'd1;
                    for (int i = 0; i < 15; i++) begin
                        r_win[i] <= r_win[i+1];
                    end
                    r_win[15] <= M_i;
                    if (t == c_load_last) begin
                        ready   <= 1'b0;
                        r_state <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    if (t == c_last_t) begin
                        w_valid <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        W_t  <= w_new;
                        t    <= t + 6'd1;
                        done <= ((t + 6'd1) == c_last_t);
                        for (int i = 0; i < 15; i++) begin
                            r_win[i] <= r_win[i+1];
                        end
                        r_win[15] <= w_new;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_msg_schedule
// Description : Directed bench for sha256_msg_schedule with a scoreboard of
//               reference schedule words and a cycle model of the control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_schedule;

    localparam int ROUNDS = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] M_i;
    logic        ready;
    logic [31:0] W_t;
    logic [5:0]  t;
    logic        w_valid;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .M_i     (M_i),
`ifdef MSG_SCHED_ABORT_EN
        .abort   (abort),
`endif
        .ready   (ready),
        .W_t     (W_t),
        .t       (t),
        .w_valid (w_valid),
        .busy    (busy),
        .done    (done)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] msg [16];
    logic [37:0] sb [$];
    int          m_pos = -1;
    logic [31:0] m_w = 32'd0;
    logic [5:0]  m_t = 6'd0;
    logic [31:0] cap [64];
    int          ready_cnt = 0;
    int          busy_cnt = 0;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_block();
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = msg[i];
        for (int i = 16; i < 64; i++) w[i] = s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16];
        for (int i = 0; i < ROUNDS; i++) sb.push_back({6'(i), w[i]});
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'd0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
    endtask

    // One clock: advance the model with the inputs seen at this edge, check, then drive M_i.
    task automatic step();
        logic [37:0] e;
        @(posedge clk);
        if (!rst_n) begin
            m_pos = -1;
            sb.delete();
            m_w = 32'd0;
            m_t = 6'd0;
        end else if (abort && m_pos >= 0) begin
            m_pos = -1;
            sb.delete();
        end else if (m_pos >= 0) begin
            m_pos = (m_pos == ROUNDS - 1) ? -1 : m_pos + 1;
        end else if (start && !abort) begin
            m_pos = 0;
            push_block();
        end
        #1;
        chk("w_valid", 32'(w_valid), 32'(m_pos >= 0));
        chk("busy", 32'(busy), 32'(m_pos >= 0));
        chk("ready", 32'(ready), 32'(m_pos >= 0 && m_pos <= 14));
        chk("done", 32'(done), 32'(m_pos == ROUNDS - 1));
        if (m_pos >= 0) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL scoreboard: observed valid word at t=%0d expected none", t);
            end else begin
                e   = sb.pop_front();
                m_w = e[31:0];
                m_t = e[37:32];
            end
            cap[m_pos] = W_t;
        end
        chk("W_t", W_t, m_w);
        chk("t", 32'(t), 32'(m_t));
        if (ready) ready_cnt++;
        if (busy)  busy_cnt++;
        if (m_pos < 0)
            M_i = msg[0];
        else if (m_pos <= 14)
            M_i = msg[m_pos + 1];
        else
            M_i = 32'hDEADBEEF;
    endtask

    initial begin
        set_abc();
        rst_n = 1'b0;
        start = 1'b1;
        abort = 1'b0;
        M_i   = msg[0];

        // Reset with start asserted: reset must win.
        repeat (2) step();
        rst_n = 1'b1;
        start = 1'b0;
        step();

        // "abc" block, single start pulse.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (ROUNDS + 3) step();
        chk("abc_W0", cap[0], 32'h61626380);
        chk("abc_W15", cap[15], 32'h00000018);
        chk("abc_W16", cap[16], 32'h61626380);
        chk("abc_W17", cap[17], 32'h000F0000);
        chk("abc_W18", cap[18], 32'h7DA86405);
        chk("abc_W19", cap[19], 32'h600003C6);
        chk("abc_W63", cap[63], 32'h12B1EDEB);

        // All-zero block: count ready and busy cycles.
        for (int i = 0; i < 16; i++) msg[i] = 32'd0;
        M_i = msg[0];
        ready_cnt = 0;
        busy_cnt  = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (ROUNDS + 3) step();
        chk("zero_ready_cycles", 32'(ready_cnt), 32'd15);
        chk("zero_busy_cycles", 32'(busy_cnt), 32'(ROUNDS));

        // start held high: back-to-back blocks with one idle cycle.
        set_abc();
        M_i = msg[0];
        start = 1'b1;
        repeat (2 * ROUNDS + 4) step();
        start = 1'b0;
        repeat (ROUNDS + 3) step();

        // start pulses during LOAD and EXPAND are ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (25) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (ROUNDS) step();

        // Reset for two cycles mid-EXPAND, then a full block.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (30) step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (ROUNDS + 3) step();
        chk("post_reset_W63", cap[63], 32'h12B1EDEB);

`ifdef MSG_SCHED_ABORT_EN
        // Abort at t=20, then abort+start in IDLE, then a full block.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        chk("abort_at_t", 32'(t), 32'd20);
        abort = 1'b1;
        step();
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (ROUNDS + 3) step();
        chk("post_abort_W63", cap[63], 32'h12B1EDEB);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
